router_fifo_pkt: RTL and testbench

Parametrised next-generation router output FIFO. It stores DATA_WIDTH-bit words, each tagged with a header flag (lfd), in a DEPTH-entry circular buffer. It tracks packet boundaries on the read side using the header length field. It adds an occupancy count, an almost-full flag, a registered data_valid and an end-of-packet pulse. One instance sits per router output channel, between the router FSM/synchronizer and the downstream read port.

---
 rtl/router_fifo_pkt_pkg.sv | 15 +
 rtl/router_fifo_pkt_if.sv | 31 +++
 rtl/router_fifo_pkt_pktcnt.sv | 58 +++++
 rtl/router_fifo_pkt.sv | 104 ++++++++++
 tb/tb_router_fifo_pkt.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/router_fifo_pkt_pkg.sv
// Shared defaults and helpers for the router output FIFO.
// Header words carry the payload length above the destination address bits.
package router_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;
  localparam int ADDR_BITS      = 2;
  localparam int HDR_LEN_LSB    = ADDR_BITS;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/router_fifo_pkt_if.sv
// Write/read handshake and status bundle between a router channel and its output FIFO.
interface router_fifo_pkt_if
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
);

  logic                          write_enb;
  logic                          lfd_state;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          read_enb;
  logic [DATA_WIDTH-1:0]         data_out;
  logic                          data_valid;
  logic                          pkt_done;
  logic                          full;
  logic                          almost_full;
  logic                          empty;
  logic [ptr_width(DEPTH)-1:0]   count;

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, data_valid, pkt_done, full, almost_full, empty, count
  );

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, data_valid, pkt_done, full, almost_full, empty, count
  );

endinterface

// File: rtl/router_fifo_pkt_pktcnt.sv
// Read-side packet tracker: counts the words left in the current packet and
// pulses pkt_done alongside data_valid for the word that ends it.
module router_fifo_pktcnt
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              soft_reset,
  input  logic                              ra_i,
  input  logic                              flag_i,
  input  logic [DATA_WIDTH-HDR_LEN_LSB-1:0] len_i,
  output logic                              pkt_done_o
);

  localparam int CW = DATA_WIDTH - 1;

  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          pkt_done_q, pkt_done_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // A header always reloads (length + parity word), silently aborting any open packet.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    pkt_done_d = 1'b0;
    if (soft_reset) begin
      pkt_cnt_d  = '0;
      pkt_done_d = 1'b0;
    end else if (ra_i) begin
      if (flag_i) begin
        pkt_cnt_d  = CW'(len_i) + CW'(1);
        pkt_done_d = 1'b0;
      end else if (pkt_cnt_q != '0) begin
        pkt_cnt_d  = pkt_cnt_q - CW'(1);
        pkt_done_d = (pkt_cnt_q == CW'(1));
      end else begin
        pkt_cnt_d  = pkt_cnt_q;
        pkt_done_d = 1'b0;
      end
    end else begin
      pkt_cnt_d  = pkt_cnt_q;
      pkt_done_d = 1'b0;
    end
  end

  assign pkt_done_o = pkt_done_q;

endmodule

// File: rtl/router_fifo_pkt.sv
// Router output-channel FIFO: circular buffer of header-tagged words with
// occupancy flags, registered read data and end-of-packet signalling.
module router_fifo_pkt
  import router_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int AFULL_THRESH = 14
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               soft_reset,
  router_fifo_pkt_if.slave   bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic [DATA_WIDTH:0]   rd_word_s;
  logic [PW-1:0]         count_s;
  logic                  full_s, empty_s, wa_s, ra_s, pkt_done_s;

  assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign count_s   = wr_ptr_q - rd_ptr_q;
  assign wa_s      = bus.write_enb && !full_s;
  assign ra_s      = bus.read_enb && !empty_s;
  assign rd_word_s = mem_q[rd_ptr_q[AW-1:0]];

  // Storage is deliberately left out of both resets; the pointers define validity.
  always_ff @(posedge clock) begin
    if (wa_s && !soft_reset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // data_out holds between reads but drops to zero the cycle after a packet ends.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      data_out_d = '0;
    end else begin
      if (wa_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (ra_s) begin
        rd_ptr_d     = rd_ptr_q + PW'(1);
        data_out_d   = rd_word_s[DATA_WIDTH-1:0];
        data_valid_d = 1'b1;
      end else if (pkt_done_s) begin
        data_out_d = '0;
      end else begin
        data_out_d = data_out_q;
      end
    end
  end

  router_fifo_pktcnt #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pktcnt (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .ra_i       (ra_s),
    .flag_i     (rd_word_s[DATA_WIDTH]),
    .len_i      (rd_word_s[DATA_WIDTH-1:HDR_LEN_LSB]),
    .pkt_done_o (pkt_done_s)
  );

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.pkt_done    = pkt_done_s;
  assign bus.full        = full_s;
  assign bus.empty       = empty_s;
  assign bus.count       = count_s;
  assign bus.almost_full = (count_s >= PW'(AFULL_THRESH));

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Randomised and directed bench for router_fifo_pkt against a queue-based packet model.
module tb_router_fifo_pkt;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic soft_reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  router_fifo_pkt_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

  router_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(14)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model: a queue of {flag,word} plus words-remaining in the open packet.
  logic [8:0] m_q[$];
  int         m_rem = 0;
  logic [7:0] m_do = 8'h00;
  logic       m_dv = 1'b0;
  logic       m_pd = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_rem = 0; m_do = 8'h00; m_dv = 1'b0; m_pd = 1'b0;
    end else if (soft_reset) begin
      m_q.delete();
      m_rem = 0; m_do = 8'h00; m_dv = 1'b0; m_pd = 1'b0;
    end else begin
      logic wa, ra, prev_pd;
      logic [8:0] w;
      wa = bus.write_enb && (m_q.size() < 16);
      ra = bus.read_enb && (m_q.size() > 0);
      prev_pd = m_pd;
      if (ra) begin
        w = m_q.pop_front();
        m_do = w[7:0];
        m_dv = 1'b1;
        m_pd = 1'b0;
        if (w[8]) begin
          m_rem = int'(w[7:2]) + 1;
        end else if (m_rem > 0) begin
          m_rem = m_rem - 1;
          m_pd = (m_rem == 0);
        end
      end else begin
        m_dv = 1'b0;
        m_pd = 1'b0;
        if (prev_pd) m_do = 8'h00;
      end
      if (wa) m_q.push_back({bus.lfd_state, bus.data_in});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model-vs-DUT compare on every falling edge.
  always @(negedge clock) begin
    chk("count",       32'(bus.count),       32'(m_q.size()));
    chk("full",        32'(bus.full),        32'(m_q.size() == 16));
    chk("empty",       32'(bus.empty),       32'(m_q.size() == 0));
    chk("almost_full", 32'(bus.almost_full), 32'(m_q.size() >= 14));
    chk("data_out",    32'(bus.data_out),    32'(m_do));
    chk("data_valid",  32'(bus.data_valid),  32'(m_dv));
    chk("pkt_done",    32'(bus.pkt_done),    32'(m_pd));
  end

  task automatic step(input logic we, input logic lfd, input logic [7:0] d,
                      input logic re, input logic sr);
    bus.write_enb = we;
    bus.lfd_state = lfd;
    bus.data_in   = d;
    bus.read_enb  = re;
    soft_reset    = sr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [7:0] exp1 [5];
    logic [7:0] v, prev;
    bus.write_enb = 1'b0; bus.lfd_state = 1'b0; bus.data_in = 8'h00; bus.read_enb = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_dout",  32'(bus.data_out), 32'd0);

    // 1: single packet, header length 3
    exp1[0] = 8'h0D; exp1[1] = 8'hA1; exp1[2] = 8'hA2; exp1[3] = 8'hA3; exp1[4] = 8'h55;
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0), exp1[i], 1'b0, 1'b0);
    chk("t1_count5", 32'(bus.count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("t1_dout", 32'(bus.data_out), 32'(exp1[i]));
      chk("t1_dv",   32'(bus.data_valid), 32'd1);
      chk("t1_pd",   32'(bus.pkt_done), 32'(i == 4));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_clear", 32'(bus.data_out), 32'd0);
    chk("t1_cnt0",  32'(bus.count), 32'd0);

    // 2: fill past capacity
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      if (i == 13) chk("t2_af13", 32'(bus.almost_full), 32'd0);
      if (i == 14) chk("t2_af14", 32'(bus.almost_full), 32'd1);
      if (i == 15) chk("t2_full15", 32'(bus.full), 32'd0);
      if (i == 16) chk("t2_full16", 32'(bus.full), 32'd1);
    end
    chk("t2_cnt16", 32'(bus.count), 32'd16);

    // 3: simultaneous read/write while full, then while empty
    step(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
    chk("t3_cnt15", 32'(bus.count), 32'd15);
    chk("t3_dout1", 32'(bus.data_out), 32'd1);
    for (int i = 2; i <= 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("t2_order", 32'(bus.data_out), 32'(i));
    end
    chk("t2_empty", 32'(bus.empty), 32'd1);
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    chk("t3_dv0", 32'(bus.data_valid), 32'd0);
    chk("t3_cnt1", 32'(bus.count), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_d77", 32'(bus.data_out), 32'h77);

    // 4: one word in flight across two pointer wraps
    prev = 8'($urandom);
    step(1'b1, 1'b0, prev, 1'b0, 1'b0);
    for (int i = 1; i < 40; i++) begin
      v = 8'($urandom);
      step(1'b1, 1'b0, v, 1'b1, 1'b0);
      chk("t4_data", 32'(bus.data_out), 32'(prev));
      chk("t4_cnt1", 32'(bus.count), 32'd1);
      prev = v;
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_last", 32'(bus.data_out), 32'(prev));

    // 5: soft reset mid-packet, then a fresh packet
    step(1'b1, 1'b1, 8'h14, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b1);
    chk("t5_empty", 32'(bus.empty), 32'd1);
    chk("t5_dout0", 32'(bus.data_out), 32'd0);
    chk("t5_pd0",   32'(bus.pkt_done), 32'd0);
    step(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hB2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("t5_pd", 32'(bus.pkt_done), 32'(i == 2));
    end
    chk("t5_dB2", 32'(bus.data_out), 32'hB2);

    // 6: asynchronous reset in the middle of a read burst
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("t6_empty", 32'(bus.empty), 32'd1);
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_dout",  32'(bus.data_out), 32'd0);
    chk("t6_dv",    32'(bus.data_valid), 32'd0);
    bus.read_enb = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    step(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hD1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hD2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("t6_pd", 32'(bus.pkt_done), 32'(i == 2));
    end

    // Random traffic, checked by the model on every cycle
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 8'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
